// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the two-master sram-like arbiter: grant states,
// response-routing IDs and access sizes.
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } gnt_e;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic gnt_id(input gnt_e g);
        return (g == GNT_DATA) ? ID_DATA : ID_INST;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// 1-bit-wide ID FIFO remembering which master issued each accepted request.
// Push when full and pop when empty are ignored.
module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // simultaneous push and pop leaves occupancy unchanged
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between instruction fetch and the memory stage;
// routes in-order responses back using the ID FIFO.
//
//  state    | meaning
//  GNT_IDLE | no frozen selection; arbitrate combinationally (data first)
//  GNT_INST | inst request shown but not yet accepted; port locked to inst
//  GNT_DATA | data request shown but not yet accepted; port locked to data
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        proto_err
);

    gnt_e gnt;
    gnt_e sel;
    logic lock;
    logic sel_req;
    logic accept;
    logic pop;
    logic fifo_head;
    logic fifo_full;
    logic fifo_empty;

    always_comb begin
        sel = GNT_IDLE;
        if (lock)          sel = gnt;
        else if (data_req) sel = GNT_DATA;
        else if (inst_req) sel = GNT_INST;
    end

    always_comb begin
        sel_req = 1'b0;
        if (sel == GNT_DATA)      sel_req = data_req;
        else if (sel == GNT_INST) sel_req = inst_req;
    end

    assign m_req   = !reset && sel_req && !fifo_full;
    assign m_wr    = (sel == GNT_DATA) ? data_wr    : inst_wr;
    assign m_size  = (sel == GNT_DATA) ? data_size  : inst_size;
    assign m_addr  = (sel == GNT_DATA) ? data_addr  : inst_addr;
    assign m_wdata = (sel == GNT_DATA) ? data_wdata : inst_wdata;

    assign accept       = m_req && m_addr_ok;
    assign inst_addr_ok = accept && (sel == GNT_INST);
    assign data_addr_ok = accept && (sel == GNT_DATA);

    assign pop          = !reset && m_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (fifo_head == ID_INST);
    assign data_data_ok = pop && (fifo_head == ID_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    // A shown-but-unaccepted request keeps the port, including while the FIFO
    // is full; a master withdrawing its request releases the lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= GNT_IDLE;
            lock      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (m_data_ok && fifo_empty) begin
                proto_err <= 1'b1;
            end
            if (sel_req && !accept && (lock || m_req)) begin
                lock <= 1'b1;
                gnt  <= sel;
            end else begin
                lock <= 1'b0;
                gnt  <= GNT_IDLE;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH(OUTS_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (gnt_id(sel)),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
